// File: rtl/console_seq.sv
// console_seq: console command sequencer between the comm link and the ADC engine.
// Latency: commands pass DECODE->RELS->WORK->TAKE->SEND; DONE lasts one cycle, then WAIT.
// Backpressure: every step holds until its done level arrives (unbounded unless CONSOLE_TIMEOUT_EN).
//
// Ports:
//   clk, rst                       single clock, asynchronous active-high reset
//   fs_adc_* / fd_adc_*            strobes to / done levels from the ADC engine
//   fs_com_send / fd_com_send      outgoing frame request / completion
//   fs_com_read / fd_com_read      incoming command present / release
//   read_btype, send_btype         received command type, outgoing frame type
//   ram_addr_init, ram_dlen        RAM window of the outgoing frame
//   frame_idx, err_cnt             conversion frame slot, saturating error count
// Optional feature: define CONSOLE_TIMEOUT_EN to abort stalled work states into ERR_SEND.
module console_seq #(
  parameter int          NUM_FRAME    = 6,
  parameter logic [11:0] FRAME_STRIDE = 12'h240,
  parameter logic [11:0] FRAME_DLEN   = 12'h202,
  parameter logic [11:0] CTRL_DLEN    = 12'h002,
  parameter logic [15:0] TIMEOUT_CYC  = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        fs_adc_init,
  output logic        fs_adc_type,
  output logic        fs_adc_conf,
  output logic        fs_adc_conv,
  output logic        fs_adc_tran,
  input  logic        fd_adc_init,
  input  logic        fd_adc_type,
  input  logic        fd_adc_conf,
  input  logic        fd_adc_conv,
  input  logic        fd_adc_tran,
  output logic        fs_com_send,
  input  logic        fd_com_send,
  input  logic        fs_com_read,
  output logic        fd_com_read,
  input  logic [3:0]  read_btype,
  output logic [3:0]  send_btype,
  output logic [11:0] ram_addr_init,
  output logic [11:0] ram_dlen,
  output logic [3:0]  frame_idx,
  output logic [7:0]  err_cnt
);

  typedef enum logic [3:0] {
    IDLE, LINK_WORK, LINK_TAKE, LINK_SEND, WAIT, DECODE,
    RELS, WORK, TAKE, SEND, DONE, ERR_SEND
  } state_t;

  localparam logic [3:0] LAST_FRAME = 4'(NUM_FRAME - 1);

  state_t      r_state, w_state_next;
  logic [3:0]  r_op;
  logic [3:0]  r_send_btype;
  logic [11:0] r_ram_addr_init;
  logic [11:0] r_ram_dlen;
  logic [3:0]  r_frame_idx;
  logic [7:0]  r_err_cnt;
  logic        r_tran_flag, r_com_flag;

  logic        w_op_type, w_op_conf, w_op_conv, w_op_err;
  logic        w_work_done, w_send_done, w_tmo_hit;
  logic [11:0] w_conv_addr;

  assign w_op_type = (r_op == 4'b0101);
  assign w_op_conf = (r_op == 4'b0110);
  assign w_op_conv = (r_op == 4'b0111);
  // 4'b1111 and every unknown code are treated alike: release the link, send nothing.
  assign w_op_err  = !(w_op_type || w_op_conf || w_op_conv);

  assign w_work_done = (w_op_type && fd_adc_type) || (w_op_conf && fd_adc_conf) ||
                       (w_op_conv && fd_adc_conv);

  // The live inputs are OR-ed in so DONE follows the later of the two events by one cycle.
  assign w_send_done = w_op_conv ? ((r_tran_flag || fd_adc_tran) && (r_com_flag || fd_com_send))
                                 : fd_com_send;

  assign w_conv_addr = {8'd0, r_frame_idx} * FRAME_STRIDE;

`ifdef CONSOLE_TIMEOUT_EN
  logic [15:0] r_tmo_cnt;

  assign w_tmo_hit = ((r_state == LINK_WORK) || (r_state == WORK)) &&
                     (r_tmo_cnt == TIMEOUT_CYC - 16'd1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_tmo_cnt <= 16'd0;
    end else if (w_state_next != r_state) begin
      r_tmo_cnt <= 16'd0;
    end else if ((r_state == LINK_WORK) || (r_state == WORK)) begin
      r_tmo_cnt <= r_tmo_cnt + 16'd1;
    end
  end
`else
  assign w_tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    fs_adc_init  = 1'b0;
    fs_adc_type  = 1'b0;
    fs_adc_conf  = 1'b0;
    fs_adc_conv  = 1'b0;
    fs_adc_tran  = 1'b0;
    fs_com_send  = 1'b0;
    fd_com_read  = 1'b0;
    case (r_state)
      IDLE:      w_state_next = LINK_WORK;
      LINK_WORK: begin
        fs_adc_init = 1'b1;
        if (fd_adc_init)    w_state_next = LINK_TAKE;
        else if (w_tmo_hit) w_state_next = ERR_SEND;
      end
      LINK_TAKE: w_state_next = LINK_SEND;
      LINK_SEND: begin
        fs_com_send = 1'b1;
        if (fd_com_send) w_state_next = WAIT;
      end
      WAIT:      if (fs_com_read) w_state_next = DECODE;
      DECODE:    w_state_next = RELS;
      RELS: begin
        fd_com_read = 1'b1;
        if (!fs_com_read) w_state_next = w_op_err ? WAIT : WORK;
      end
      WORK: begin
        fs_adc_type = w_op_type;
        fs_adc_conf = w_op_conf;
        fs_adc_conv = w_op_conv;
        if (w_work_done)    w_state_next = TAKE;
        else if (w_tmo_hit) w_state_next = ERR_SEND;
      end
      TAKE:      w_state_next = SEND;
      SEND: begin
        fs_com_send = 1'b1;
        fs_adc_tran = w_op_conv;
        if (w_send_done) w_state_next = DONE;
      end
      DONE:      w_state_next = WAIT;
      ERR_SEND: begin
        fs_com_send = 1'b1;
        if (fd_com_send) w_state_next = WAIT;
      end
      default:   w_state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_op            <= 4'h0;
      r_send_btype    <= 4'b0000;
      r_ram_addr_init <= 12'hFE0;
      r_ram_dlen      <= 12'h000;
      r_frame_idx     <= 4'd0;
      r_err_cnt       <= 8'd0;
      r_tran_flag     <= 1'b0;
      r_com_flag      <= 1'b0;
    end else begin
      case (r_state)
        IDLE, WAIT: begin
          r_send_btype    <= 4'b0000;
          r_ram_addr_init <= 12'hFE0;
          r_ram_dlen      <= 12'h000;
        end
        LINK_TAKE: begin
          r_send_btype    <= 4'b1000;
          r_ram_addr_init <= 12'hFCC;
          r_ram_dlen      <= CTRL_DLEN;
        end
        DECODE: r_op <= read_btype;
        TAKE: begin
          if (w_op_conv) begin
            // Even/odd frame types let the host tell ping-pong halves apart.
            r_send_btype    <= r_frame_idx[0] ? 4'b1110 : 4'b1101;
            r_ram_addr_init <= w_conv_addr;
            r_ram_dlen      <= FRAME_DLEN;
            r_frame_idx     <= (r_frame_idx == LAST_FRAME) ? 4'd0 : r_frame_idx + 4'd1;
          end else begin
            r_send_btype    <= w_op_type ? 4'b1001 : 4'b1010;
            r_ram_addr_init <= w_op_type ? 12'hFC0 : 12'hFC4;
            r_ram_dlen      <= CTRL_DLEN;
          end
        end
        SEND: begin
          if (w_op_conv) begin
            if (fd_adc_tran) r_tran_flag <= 1'b1;
            if (fd_com_send) r_com_flag  <= 1'b1;
          end
        end
        DONE: begin
          r_tran_flag <= 1'b0;
          r_com_flag  <= 1'b0;
        end
        default: ;
      endcase
      if ((w_state_next == ERR_SEND) && (r_state != ERR_SEND)) begin
        r_send_btype    <= 4'b1111;
        r_ram_addr_init <= 12'hFE0;
        r_ram_dlen      <= CTRL_DLEN;
        if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'd1;
      end
    end
  end

  assign send_btype    = r_send_btype;
  assign ram_addr_init = r_ram_addr_init;
  assign ram_dlen      = r_ram_dlen;
  assign frame_idx     = r_frame_idx;
  assign err_cnt       = r_err_cnt;

endmodule

// File: tb/tb_console_seq.sv
// tb_console_seq: directed-vector bench for console_seq.
// Inputs are driven and outputs sampled on the falling clock edge.
// All waits on DUT strobes are bounded by a cycle budget.
module tb_console_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fs_adc_init, fs_adc_type, fs_adc_conf, fs_adc_conv, fs_adc_tran;
  logic        fd_adc_init = 1'b0, fd_adc_type = 1'b0, fd_adc_conf = 1'b0;
  logic        fd_adc_conv = 1'b0, fd_adc_tran = 1'b0;
  logic        fs_com_send, fd_com_read;
  logic        fd_com_send = 1'b0, fs_com_read = 1'b0;
  logic [3:0]  read_btype = 4'h0;
  logic [3:0]  send_btype, frame_idx;
  logic [11:0] ram_addr_init, ram_dlen;
  logic [7:0]  err_cnt;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  console_seq #(
    .NUM_FRAME(6), .FRAME_STRIDE(12'h240), .FRAME_DLEN(12'h202),
    .CTRL_DLEN(12'h002), .TIMEOUT_CYC(16'd16)
  ) dut (
    .clk(clk), .rst(rst),
    .fs_adc_init(fs_adc_init), .fs_adc_type(fs_adc_type), .fs_adc_conf(fs_adc_conf),
    .fs_adc_conv(fs_adc_conv), .fs_adc_tran(fs_adc_tran),
    .fd_adc_init(fd_adc_init), .fd_adc_type(fd_adc_type), .fd_adc_conf(fd_adc_conf),
    .fd_adc_conv(fd_adc_conv), .fd_adc_tran(fd_adc_tran),
    .fs_com_send(fs_com_send), .fd_com_send(fd_com_send),
    .fs_com_read(fs_com_read), .fd_com_read(fd_com_read),
    .read_btype(read_btype), .send_btype(send_btype),
    .ram_addr_init(ram_addr_init), .ram_dlen(ram_dlen),
    .frame_idx(frame_idx), .err_cnt(err_cnt)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic sel_sig(input int w);
    case (w)
      0: return fs_adc_init;
      1: return fs_adc_type;
      2: return fs_adc_conf;
      3: return fs_adc_conv;
      4: return fs_adc_tran;
      5: return fs_com_send;
      default: return fd_com_read;
    endcase
  endfunction

  // Returns on the first falling edge where the selected output is high.
  task automatic wait_for(input int w, input string tag);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (sel_sig(w)) break;
    end
    chk(tag, {31'd0, sel_sig(w)}, 32'd1);
  endtask

  function automatic logic [4:0] all_fs();
    return {fs_adc_init, fs_adc_type, fs_adc_conf, fs_adc_conv, fs_adc_tran};
  endfunction

  task automatic do_link();
    wait_for(0, "link_work");
    repeat (3) @(negedge clk);
    fd_adc_init = 1'b1;
    @(negedge clk);
    fd_adc_init = 1'b0;
    wait_for(5, "link_send");
    chk("link_btype", {28'd0, send_btype}, 32'h8);
    chk("link_addr", {20'd0, ram_addr_init}, 32'hFCC);
    chk("link_dlen", {20'd0, ram_dlen}, 32'h002);
    repeat (3) @(negedge clk);
    chk("link_send_hold", {31'd0, fs_com_send}, 32'd1);
    fd_com_send = 1'b1;
    @(negedge clk);
    fd_com_send = 1'b0;
    chk("link_to_wait", {26'd0, fs_com_send, all_fs()}, 32'd0);
  endtask

  task automatic send_cmd(input logic [3:0] bt);
    read_btype  = bt;
    fs_com_read = 1'b1;
    wait_for(6, "rels");
    fs_com_read = 1'b0;
  endtask

  task automatic do_ctrl(input logic [3:0] bt, input int w, input logic [3:0] eb,
                         input logic [11:0] ea);
    send_cmd(bt);
    wait_for(w, "ctrl_strobe");
    if (w == 1) fd_adc_type = 1'b1; else fd_adc_conf = 1'b1;
    @(negedge clk);
    fd_adc_type = 1'b0;
    fd_adc_conf = 1'b0;
    wait_for(5, "ctrl_send");
    chk("ctrl_btype", {28'd0, send_btype}, {28'd0, eb});
    chk("ctrl_addr", {20'd0, ram_addr_init}, {20'd0, ea});
    chk("ctrl_dlen", {20'd0, ram_dlen}, 32'h002);
    chk("ctrl_no_tran", {31'd0, fs_adc_tran}, 32'd0);
    fd_com_send = 1'b1;
    @(negedge clk);
    fd_com_send = 1'b0;
    chk("ctrl_done", {31'd0, fs_com_send}, 32'd0);
    @(negedge clk);
  endtask

  task automatic do_conv(input logic [11:0] ea, input logic [3:0] eb, input logic [3:0] ei,
                         input bit late_tran);
    send_cmd(4'b0111);
    wait_for(3, "conv_strobe");
    chk("conv_only", {28'd0, fs_adc_init, fs_adc_type, fs_adc_conf, fs_adc_tran}, 32'd0);
    fd_adc_conv = 1'b1;
    @(negedge clk);
    fd_adc_conv = 1'b0;
    wait_for(5, "conv_send");
    chk("conv_addr", {20'd0, ram_addr_init}, {20'd0, ea});
    chk("conv_btype", {28'd0, send_btype}, {28'd0, eb});
    chk("conv_dlen", {20'd0, ram_dlen}, 32'h202);
    chk("conv_idx", {28'd0, frame_idx}, {28'd0, ei});
    chk("conv_tran", {31'd0, fs_adc_tran}, 32'd1);
    fd_com_send = 1'b1;
    if (late_tran) begin
      for (int i = 0; i < 4; i++) begin
        @(negedge clk);
        fd_com_send = 1'b0;
        chk("sticky_hold", {30'd0, fs_com_send, fs_adc_tran}, 32'd3);
      end
    end
    fd_adc_tran = 1'b1;
    @(negedge clk);
    fd_com_send = 1'b0;
    fd_adc_tran = 1'b0;
    chk("conv_done", {30'd0, fs_com_send, fs_adc_tran}, 32'd0);
    @(negedge clk);
  endtask

  initial begin
    @(negedge clk);
    chk("rst_btype", {28'd0, send_btype}, 32'h0);
    chk("rst_addr", {20'd0, ram_addr_init}, 32'hFE0);
    chk("rst_dlen", {20'd0, ram_dlen}, 32'h0);
    chk("rst_idx_err", {20'd0, frame_idx, err_cnt}, 32'h0);
    chk("rst_strobes", {25'd0, all_fs(), fs_com_send, fd_com_read}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    do_link();

    // Unknown command: link release only, no ADC activity, back to WAIT.
    send_cmd(4'b0011);
    fs_com_read = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_rels_hold", {31'd0, fd_com_read}, 32'd1);
    end
    fs_com_read = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("err_quiet", {25'd0, all_fs(), fs_com_send, fd_com_read}, 32'd0);
    end

    do_ctrl(4'b0101, 1, 4'b1001, 12'hFC0);
    do_ctrl(4'b0110, 2, 4'b1010, 12'hFC4);

    do_conv(12'h000, 4'hD, 4'd1, 1'b0);
    do_conv(12'h240, 4'hE, 4'd2, 1'b1);
    do_conv(12'h480, 4'hD, 4'd3, 1'b0);
    do_conv(12'h6C0, 4'hE, 4'd4, 1'b0);
    do_conv(12'h900, 4'hD, 4'd5, 1'b1);
    do_conv(12'hB40, 4'hE, 4'd0, 1'b0);
    do_conv(12'h000, 4'hD, 4'd1, 1'b0);

`ifdef CONSOLE_TIMEOUT_EN
    begin
      int cyc;
      send_cmd(4'b0110);
      wait_for(2, "tmo_work");
      cyc = 1;
      for (int i = 0; i < 100; i++) begin
        @(negedge clk);
        if (!fs_adc_conf) break;
        cyc++;
      end
      chk("tmo_cycles", cyc, 32'd16);
      chk("tmo_send", {31'd0, fs_com_send}, 32'd1);
      chk("tmo_btype", {28'd0, send_btype}, 32'hF);
      chk("tmo_addr", {20'd0, ram_addr_init}, 32'hFE0);
      chk("tmo_dlen", {20'd0, ram_dlen}, 32'h002);
      chk("tmo_errcnt", {24'd0, err_cnt}, 32'd1);
      chk("tmo_idx", {28'd0, frame_idx}, 32'd1);
      fd_com_send = 1'b1;
      @(negedge clk);
      fd_com_send = 1'b0;
      chk("tmo_to_wait", {31'd0, fs_com_send}, 32'd0);
    end
`else
    chk("errcnt_zero", {24'd0, err_cnt}, 32'd0);
`endif

    // Reset in the middle of a conversion send.
    send_cmd(4'b0111);
    wait_for(3, "rst_conv_strobe");
    fd_adc_conv = 1'b1;
    @(negedge clk);
    fd_adc_conv = 1'b0;
    wait_for(5, "rst_conv_send");
    rst = 1'b1;
    #1;
    chk("rst_mid_strobes", {25'd0, all_fs(), fs_com_send, fd_com_read}, 32'd0);
    chk("rst_mid_idx", {28'd0, frame_idx}, 32'd0);
    chk("rst_mid_btype", {28'd0, send_btype}, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    do_link();
    do_conv(12'h000, 4'hD, 4'd1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
